branch_history_table: RTL and testbench

- Storage and update stage for the dynamic branch predictor.
- Holds 2^IDX_W entries of {valid, tag, 2-bit saturating counter}.
- Read side: a registered lookup that drives rd_valid/rd_tag/rd_counter into the downstream prediction-decision logic, together with the lookup tag.
- Update side: applies branch resolutions from execute, by saturating counter update or by allocation on tag miss.

---
 rtl/branch_history_table_pkg.sv | 32 +++
 rtl/branch_history_table_sat_counter2.sv | 30 +++
 rtl/branch_history_table.sv | 132 +++++++++++++
 tb/tb_branch_history_table.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_history_table_pkg.sv
// Shared definitions for the branch history table and its neighbours.
// Latency: n/a (constants, types and a slice helper only).
// Backpressure: n/a.
//
// Fetch and prediction-decision stages import the same PC slice constants so
// that every stage agrees on which PC bits form the index and which form the tag.
package branch_history_table_pkg;

    localparam int BHT_IDX_W  = 5;
    localparam int BHT_TAG_W  = 5;
    localparam int BHT_PC_W   = 32;

    // PCs are word aligned, so the two lowest bits never carry information.
    localparam int PC_IDX_LSB = 2;

    // Two-bit saturating counter encodings.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Counter value every entry takes at reset (weakly not-taken).
    localparam logic [1:0] BHT_CNT_INIT = WNT;

    // Lowest PC bit of the tag field for a given index width.
    function automatic int tag_lsb(input int idx_w);
        return PC_IDX_LSB + idx_w;
    endfunction

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// Two-bit saturating counter next-state function.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   cnt      - current counter value
//   taken    - resolved branch direction
//   cnt_next - counter after one training step, clamped at 00 and 11
module sat_counter2
    import branch_history_table_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != ST) begin
                cnt_next = cnt + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                cnt_next = cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: {valid, tag, 2-bit counter} storage plus update stage.
// Latency: lookup 1 cycle (registered outputs); update written on the same edge.
// Backpressure: none; lk_en=0 stalls (holds) lookup outputs, one update per cycle.
//
// Ports:
//   clk, rst_n                           - clock, async active-low reset
//   lk_en, lk_pc                         - lookup request (lk_en=0 holds outputs)
//   rd_valid, rd_tag, rd_counter, tag    - registered lookup result and PC tag
//   upd_en, upd_pc, upd_taken            - branch resolution from execute
//   upd_hit                              - registered: last update hit a valid entry
//
// Build option: define BHT_BYPASS_EN to forward a same-cycle, same-index update
// into the lookup result; otherwise the lookup reads the pre-update entry.
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int         IDX_W    = BHT_IDX_W,
    parameter int         TAG_W    = BHT_TAG_W,
    parameter int         PC_W     = BHT_PC_W,
    parameter logic [1:0] CNT_INIT = BHT_CNT_INIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_en,
    input  logic [PC_W-1:0]  lk_pc,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [1:0]       rd_counter,
    output logic [TAG_W-1:0] tag,
    input  logic             upd_en,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    output logic             upd_hit
);

    localparam int DEPTH   = 1 << IDX_W;
    localparam int IDX_LSB = PC_IDX_LSB;
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
    localparam int TAG_LSB = tag_lsb(IDX_W);
    localparam int TAG_MSB = TAG_LSB + TAG_W - 1;

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;
    logic [DEPTH-1:0][1:0]       cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tg;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tg;

    assign lk_idx  = lk_pc[IDX_MSB:IDX_LSB];
    assign lk_tg   = lk_pc[TAG_MSB:TAG_LSB];
    assign upd_idx = upd_pc[IDX_MSB:IDX_LSB];
    assign upd_tg  = upd_pc[TAG_MSB:TAG_LSB];

    // Alignment bits and PC bits above the tag do not take part in indexing.
    logic unused_pc_bits;
    if (PC_W > TAG_MSB + 1) begin : g_pc_hi
        assign unused_pc_bits = ^{lk_pc[PC_W-1:TAG_MSB+1], upd_pc[PC_W-1:TAG_MSB+1],
                                  lk_pc[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0]};
    end else begin : g_pc_nohi
        assign unused_pc_bits = ^{lk_pc[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0]};
    end

    // ---------------- update path ----------------
    logic       upd_hit_c;
    logic [1:0] sat_next;
    logic [1:0] new_cnt;

    assign upd_hit_c = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tg);

    sat_counter2 u_sat (
        .cnt      (cnt_q[upd_idx]),
        .taken    (upd_taken),
        .cnt_next (sat_next)
    );

    // On a miss the entry is reallocated at the weak state of the resolved direction.
    assign new_cnt = upd_hit_c ? sat_next : (upd_taken ? WT : WNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (upd_en) begin
            // On a hit the stored tag already equals upd_tg, so one write covers both cases.
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tg;
            cnt_q[upd_idx]   <= new_cnt;
        end
    end

    // ---------------- lookup path ----------------
    logic             lk_valid_c;
    logic [TAG_W-1:0] lk_tag_c;
    logic [1:0]       lk_cnt_c;

`ifdef BHT_BYPASS_EN
    logic fwd;
    assign fwd        = upd_en && (upd_idx == lk_idx);
    assign lk_valid_c = fwd ? 1'b1    : valid_q[lk_idx];
    assign lk_tag_c   = fwd ? upd_tg  : tag_q[lk_idx];
    assign lk_cnt_c   = fwd ? new_cnt : cnt_q[lk_idx];
`else
    // Read-before-write: a same-index update becomes visible on the next lookup.
    assign lk_valid_c = valid_q[lk_idx];
    assign lk_tag_c   = tag_q[lk_idx];
    assign lk_cnt_c   = cnt_q[lk_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid   <= 1'b0;
            rd_tag     <= '0;
            rd_counter <= CNT_INIT;
            tag        <= '0;
            upd_hit    <= 1'b0;
        end else begin
            if (lk_en) begin
                rd_valid   <= lk_valid_c;
                rd_tag     <= lk_tag_c;
                rd_counter <= lk_cnt_c;
                tag        <= lk_tg;
            end
            upd_hit <= upd_en && upd_hit_c;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table.
// Latency: a reference model predicts the outputs of every clock edge.
// Backpressure: none; a monitor pops one expectation per edge and compares.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lk_en;
    logic [31:0] lk_pc;
    logic        rd_valid;
    logic [4:0]  rd_tag;
    logic [1:0]  rd_counter;
    logic [4:0]  tag;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_hit;

    always #5 clk = ~clk;

    branch_history_table dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_en      (lk_en),
        .lk_pc      (lk_pc),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_counter (rd_counter),
        .tag        (tag),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_hit    (upd_hit)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rt;
        logic [1:0] rc;
        logic [4:0] t;
        logic       h;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------- reference model ----------------
    int   m_valid[32];
    int   m_tag[32];
    int   m_cnt[32];
    obs_t m_out;

    function automatic int pc_idx(input logic [31:0] pc);
        return int'(pc >> 2) % 32;
    endfunction

    function automatic int pc_tag(input logic [31:0] pc);
        return int'(pc >> 7) % 32;
    endfunction

    function automatic int trained(input int c, input logic tk);
        if (tk) return (c + 1 > 3) ? 3 : c + 1;
        return (c - 1 < 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_cnt[i]   = 1;
        end
        m_out = {1'b0, 5'd0, 2'd1, 5'd0, 1'b0};
    endtask

    task automatic model_step();
        int  li, lt, ui, ut, nc;
        bit  hit;
        li  = pc_idx(lk_pc);
        lt  = pc_tag(lk_pc);
        ui  = pc_idx(upd_pc);
        ut  = pc_tag(upd_pc);
        hit = (m_valid[ui] == 1) && (m_tag[ui] == ut);
        nc  = hit ? trained(m_cnt[ui], upd_taken) : (upd_taken ? 2 : 1);
        if (lk_en) begin
            m_out.v  = (m_valid[li] == 1);
            m_out.rt = 5'(m_tag[li]);
            m_out.rc = 2'(m_cnt[li]);
`ifdef BHT_BYPASS_EN
            if (upd_en && ui == li) begin
                m_out.v  = 1'b1;
                m_out.rt = 5'(ut);
                m_out.rc = 2'(nc);
            end
`endif
            m_out.t = 5'(lt);
        end
        m_out.h = upd_en && hit;
        if (upd_en) begin
            m_valid[ui] = 1;
            m_tag[ui]   = ut;
            m_cnt[ui]   = nc;
        end
    endtask

    // Predictor: one expectation per rising edge; an asynchronous reset between
    // edges clears the model without producing an expectation of its own.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                if (clk) exp_q.push_back(m_out);
            end else begin
                model_step();
                exp_q.push_back(m_out);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        obs_t act;
        obs_t exp;
        forever begin
            @(posedge clk);
            #2;
            act = {rd_valid, rd_tag, rd_counter, tag, upd_hit};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow t=%0t actual=%h required=<an expectation>", $time, act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL lookup_outputs t=%0t actual v=%b rt=%h rc=%b t=%h h=%b required v=%b rt=%h rc=%b t=%h h=%b",
                             $time, act.v, act.rt, act.rc, act.t, act.h,
                             exp.v, exp.rt, exp.rc, exp.t, exp.h);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge; the inputs are sampled at the following rising edge.
    task automatic drive(input bit le, input logic [31:0] lp,
                         input bit ue, input logic [31:0] up, input bit tk);
        lk_en     = le;
        lk_pc     = lp;
        upd_en    = ue;
        upd_pc    = up;
        upd_taken = tk;
        @(negedge clk);
    endtask

    task automatic train(input logic [31:0] pc, input bit tk, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 32'h0, 1'b1, pc, tk);
            drive(1'b1, pc, 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        obs_t act;
        rst_n     = 1'b0;
        lk_en     = 1'b0;
        lk_pc     = '0;
        upd_en    = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Every entry reads back invalid with the initial counter.
        for (int i = 0; i < 32; i++) drive(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0);

        // Allocate on a taken miss, then train up to saturation.
        train(32'h0000_0104, 1'b1, 1);
        train(32'h0000_0104, 1'b1, 4);
        // Decay back down through every state and saturate at 00.
        train(32'h0000_0104, 1'b0, 4);

        // 0x1104 differs from 0x104 only above the tag field, so it trains the same entry.
        train(32'h0000_0104, 1'b1, 3);
        train(32'h0000_1104, 1'b0, 1);
        // 0x904 shares the index but carries a different tag: reallocation.
        train(32'h0000_0104, 1'b1, 3);
        train(32'h0000_0904, 1'b0, 1);
        drive(1'b1, 32'h0000_0104, 1'b0, 32'h0, 1'b0);

        // Same-cycle lookup and update to one index, entry at 01.
        train(32'h0000_0208, 1'b0, 1);
        drive(1'b1, 32'h0000_0208, 1'b1, 32'h0000_0208, 1'b1);
        drive(1'b1, 32'h0000_0208, 1'b0, 32'h0, 1'b0);
        // Different indices in the same cycle.
        drive(1'b1, 32'h0000_0104, 1'b1, 32'h0000_0208, 1'b1);

        // Stall: outputs hold while lk_pc wanders.
        drive(1'b1, 32'h0000_0208, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, $urandom, 1'b0, 32'h0, 1'b0);

        // Random traffic over a small tag set so hits, misses and aliases all occur.
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] lp;
            logic [31:0] up;
            lp = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
            up = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
            if ($urandom_range(0, 3) == 0) up[11:2] = lp[11:2];
            drive(1'($urandom_range(0, 4) != 0), lp, 1'($urandom_range(0, 2) != 0), up, 1'($urandom));
        end

        // Asynchronous reset between edges with an update pending.
        train(32'h0000_030C, 1'b1, 2);
        lk_en     = 1'b1;
        lk_pc     = 32'h0000_030C;
        upd_en    = 1'b1;
        upd_pc    = 32'h0000_030C;
        upd_taken = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        act = {rd_valid, rd_tag, rd_counter, tag, upd_hit};
        n_vec++;
        if (act !== {1'b0, 5'd0, 2'b01, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset_clear actual=%h required=%h", act, {1'b0, 5'd0, 2'b01, 5'd0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h0000_030C, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0000_0104, 1'b0, 32'h0, 1'b0);

        lk_en  = 1'b0;
        upd_en = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
